ifetch_unit: RTL and testbench

- Instruction-fetch initiator that drives the instruction-cache read port (64-bit address, 32-bit big-endian-assembled word, stall).
- Owns the fetch PC and buffers returned instructions with their PCs in a small FIFO feeding decode through a valid/ready handshake.
- Accepts a redirect (branch/trap/jump) that flushes the buffer and restarts fetch.

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/ifetch_unit_fetch_queue.sv | 65 ++++++
 rtl/ifetch_unit.sv | 96 +++++++++
 tb/tb_ifetch_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared constants and types for the instruction-fetch unit
package ifetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned XLEN    = 64;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/ifetch_unit_fetch_queue.sv
// rtl/ifetch_unit_fetch_queue.sv - synchronous FIFO of fetched {pc, instr} entries with flush
module fetch_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fq_entry_t        push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output fq_entry_t        head
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    fq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; head is qualified by empty downstream.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - fetch PC, icache request logic and decode-facing fetch queue
// Optional fetch/stall statistics counters under IFETCH_STATS_EN.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          FQ_DEPTH = 4,
    localparam int         PTR_W    = $clog2(FQ_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    output logic [XLEN-1:0]     icache_addr,
    output logic                icache_read_en,
    input  logic [INSTR_W-1:0]  icache_data,
    input  logic                icache_stall,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [INSTR_W-1:0]  out_instr
`ifdef IFETCH_STATS_EN
    ,
    output logic [63:0]         stat_fetches,
    output logic [63:0]         stat_stall_cycles
`endif
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic            fetch_hit;
    logic            pop;
    logic            fq_full;
    logic            fq_empty;
    logic [PTR_W:0]  fq_count;
    fq_entry_t       fq_head;
    fq_entry_t       fq_wdata;

    assign icache_addr    = pc;
    assign icache_read_en = (state == RUN) && !fq_full && !redirect_valid;
    assign fetch_hit      = icache_read_en && !icache_stall;
    assign pop            = out_valid && out_ready;
    assign out_valid      = (fq_count != '0);
    assign out_pc         = fq_empty ? '0 : fq_head.pc;
    assign out_instr      = fq_empty ? '0 : fq_head.instr;
    assign fq_wdata       = '{pc: pc, instr: icache_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            if (state == BOOT) begin
                state <= RUN;
            end
            // Redirect wins over fetch; low address bits are dropped.
            if (redirect_valid) begin
                pc <= redirect_pc & ~XLEN'(3);
            end else if (fetch_hit) begin
                pc <= pc + XLEN'(PC_STEP);
            end
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (fetch_hit),
        .push_data (fq_wdata),
        .pop       (pop),
        .flush     (redirect_valid),
        .full      (fq_full),
        .empty     (fq_empty),
        .count     (fq_count),
        .head      (fq_head)
    );

`ifdef IFETCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_fetches      <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (fetch_hit) begin
                stat_fetches <= stat_fetches + 64'd1;
            end
            if (icache_read_en && icache_stall) begin
                stat_stall_cycles <= stat_stall_cycles + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] icache_addr;
    logic        icache_read_en;
    logic [31:0] icache_data;
    logic        icache_stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
`ifdef IFETCH_STATS_EN
    logic [63:0] stat_fetches;
    logic [63:0] stat_stall_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int hits;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h0000_0013;
            64'h4:   return 32'h0010_0093;
            64'h8:   return 32'h0020_0113;
            64'hC:   return 32'h0030_0193;
            default: return a[31:0] ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign icache_data = mem_word(icache_addr);

    ifetch_unit #(
        .RESET_PC (64'h0),
        .FQ_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_addr    (icache_addr),
        .icache_read_en (icache_read_en),
        .icache_data    (icache_data),
        .icache_stall   (icache_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
`ifdef IFETCH_STATS_EN
        ,
        .stat_fetches      (stat_fetches),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in BOOT, one edge before RUN.
    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        icache_stall   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = 1'b1;
        step();
        check("rst_read_en", 64'(icache_read_en), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_addr", icache_addr, 64'h0);
        check("rst_out_pc", out_pc, 64'h0);
        check("rst_out_instr", 64'(out_instr), 64'h0);

        // Boot stream with decode always ready
        reset = 1'b0;
        step();
        check("boot_valid_e1", 64'(out_valid), 64'h0);
        check("boot_read_en_e1", 64'(icache_read_en), 64'h1);
        check("boot_addr_e1", icache_addr, 64'h0);
        step();
        check("boot_pc0", out_pc, 64'h0);
        check("boot_ins0", 64'(out_instr), 64'h0000_0013);
        check("boot_addr_e2", icache_addr, 64'h4);
        step();
        check("boot_pc1", out_pc, 64'h4);
        check("boot_ins1", 64'(out_instr), 64'h0010_0093);
        check("boot_addr_e3", icache_addr, 64'h8);
        step();
        check("boot_pc2", out_pc, 64'h8);
        check("boot_ins2", 64'(out_instr), 64'h0020_0113);
        step();
        check("boot_pc3", out_pc, 64'hC);
        check("boot_ins3", 64'(out_instr), 64'h0030_0193);
        check("boot_valid", 64'(out_valid), 64'h1);

        // Backpressure fills the queue, then drains in order
        out_ready = 1'b0;
        do_reset();
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            if (icache_read_en && !icache_stall) hits++;
            step();
        end
        check("bp_hits", 64'(hits), 64'd4);
        check("bp_read_en", 64'(icache_read_en), 64'h0);
        check("bp_addr", icache_addr, 64'h10);
        check("bp_head", out_pc, 64'h0);
        out_ready = 1'b1;
        step();
        check("bp_drain1", out_pc, 64'h4);
        step();
        check("bp_drain2", out_pc, 64'h8);
        step();
        check("bp_drain3", out_pc, 64'hC);
        step();
        check("bp_refill_pc", out_pc, 64'h10);
        check("bp_refill_ins", 64'(out_instr), 64'h5A5A_0010);

        // Stall for three cycles at pc 0x8
        do_reset();
        step();
        step();
        step();
        check("st_addr_pre", icache_addr, 64'h8);
        icache_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("st_addr_hold", icache_addr, 64'h8);
            step();
        end
        icache_stall = 1'b0;
        check("st_no_write", 64'(out_valid), 64'h0);
        check("st_addr_post", icache_addr, 64'h8);
        step();
        check("st_next_pc", out_pc, 64'h8);
        check("st_next_ins", 64'(out_instr), 64'h0020_0113);

        // Redirect with a full queue and a concurrent pop
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        check("rd_full_valid", 64'(out_valid), 64'h1);
        check("rd_full_read_en", 64'(icache_read_en), 64'h0);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1003;
        #1;
        check("rd_no_fetch", 64'(icache_read_en), 64'h0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("rd_flushed", 64'(out_valid), 64'h0);
        check("rd_addr", icache_addr, 64'h1000);
        step();
        check("rd_new_pc", out_pc, 64'h1000);
        check("rd_new_ins", 64'(out_instr), 64'h5A5A_1000);

        // Asynchronous reset with three entries queued
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        check("ar_pre_valid", 64'(out_valid), 64'h1);
        check("ar_pre_pc", out_pc, 64'h0);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", 64'(out_valid), 64'h0);
        check("ar_read_en", 64'(icache_read_en), 64'h0);
        check("ar_addr", icache_addr, 64'h0);
        check("ar_out_pc", out_pc, 64'h0);
        step();

        // Redirect in BOOT to the top of the address space, then wrap
        reset          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        #1;
        check("wr_addr", icache_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wr_read_en", 64'(icache_read_en), 64'h1);
        step();
        check("wr_addr_wrap", icache_addr, 64'h0);
        icache_stall = 1'b1;
        step();
        icache_stall = 1'b0;
        check("wr_addr_stalled", icache_addr, 64'h0);
        step();
`ifdef IFETCH_STATS_EN
        check("stat_fetches", stat_fetches, 64'd2);
        check("stat_stalls", stat_stall_cycles, 64'd1);
`endif
        check("wr_pc0", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wr_ins0", 64'(out_instr), 64'hA5A5_FFFC);
        out_ready = 1'b1;
        step();
        check("wr_pc1", out_pc, 64'h0);
        check("wr_ins1", 64'(out_instr), 64'h0000_0013);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
